// File: rtl/ped_request_pkg.sv
// Shared definitions for the pedestrian-request path (state encoding, 50 MHz timing).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ped_request_pkg;

  // State encoding shared with the intersection controller
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_LOCKOUT = 2'd2
  } ped_state_t;

  // Timing derived from the 50 MHz system clock
  localparam int CLK_HZ           = 50_000_000;
  localparam int BLINK_HALF_50MHZ = CLK_HZ / 4;   // 250 ms half-period -> 2 Hz blink
  localparam int LOCKOUT_50MHZ    = CLK_HZ;       // 1 s lockout after service
  localparam int CNT_W_50MHZ      = 26;           // holds both constants above

endpackage

// File: rtl/ped_request_edge_detect_n.sv
// Falling-edge detector for a debounced active-low level.
// Latency: press is combinational from the sampled level and one registered history bit.
// Backpressure: none; press is a single-cycle qualifier the consumer must take or drop.
module edge_detect_n (
  input  logic clk_50_mhz,
  input  logic rst,
  input  logic sig_n,
  output logic press
);

  logic sig_prev;

  // History resets to 0 so a level held low through reset never looks like a new edge
  always_ff @(posedge clk_50_mhz or posedge rst) begin
    if (rst) begin
      sig_prev <= 1'b0;
    end else begin
      sig_prev <= sig_n;
    end
  end

  assign press = sig_prev & ~sig_n;

endmodule

// File: rtl/ped_request.sv
// Latches each button press into a held pedestrian request, blinks WAIT while pending, locks out after ack.
// Latency: req/press_pulse register one edge after the sampled falling edge (1-2 edges from btn_n fall).
// Backpressure: none; presses in LOCKOUT or coincident with ack are discarded.
module ped_request
  import ped_request_pkg::*;
#(
  parameter int BLINK_HALF     = BLINK_HALF_50MHZ,
  parameter int LOCKOUT_CYCLES = LOCKOUT_50MHZ,
  parameter int CNT_W          = CNT_W_50MHZ
) (
  input  logic       clk_50_mhz,
  input  logic       rst,
  input  logic       btn_n,
  input  logic       ack,
  output logic       req,
  output logic       wait_lamp,
  output logic       press_pulse,
  output logic [7:0] press_count
);

  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);
  localparam logic [CNT_W-1:0] LOCK_LOAD  = CNT_W'(LOCKOUT_CYCLES);

  ped_state_t       state;
  logic [CNT_W-1:0] timer;
  logic             press;

  edge_detect_n u_edge (
    .clk_50_mhz (clk_50_mhz),
    .rst        (rst),
    .sig_n      (btn_n),
    .press      (press)
  );

  // Request FSM; the single timer paces the blink while pending and counts down the lockout
  always_ff @(posedge clk_50_mhz or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      req         <= 1'b0;
      wait_lamp   <= 1'b0;
      press_pulse <= 1'b0;
      press_count <= 8'd0;
      timer       <= '0;
    end else begin
      press_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (press) begin
            state       <= ST_PENDING;
            req         <= 1'b1;
            press_pulse <= 1'b1;
            wait_lamp   <= 1'b1;
            timer       <= '0;
            if (press_count != 8'hFF) press_count <= press_count + 8'd1;
          end
        end
        ST_PENDING: begin
          if (ack) begin
            // ack wins over a coincident press: that press is dropped entirely
            state     <= ST_LOCKOUT;
            req       <= 1'b0;
            wait_lamp <= 1'b0;
            timer     <= LOCK_LOAD;
          end else begin
            if (press) begin
              press_pulse <= 1'b1;
              if (press_count != 8'hFF) press_count <= press_count + 8'd1;
            end
            if (timer == BLINK_LAST) begin
              wait_lamp <= ~wait_lamp;
              timer     <= '0;
            end else begin
              timer <= timer + CNT_W'(1);
            end
          end
        end
        ST_LOCKOUT: begin
          // Lasts LOCKOUT_CYCLES+1 cycles because the zero count is spent here too
          if (timer == '0) begin
            state <= ST_IDLE;
          end else begin
            timer <= timer - CNT_W'(1);
          end
        end
        default: begin
          state     <= ST_IDLE;
          req       <= 1'b0;
          wait_lamp <= 1'b0;
          timer     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ped_request.sv
// Directed bench for ped_request with short timing (BLINK_HALF=4, LOCKOUT_CYCLES=8, CNT_W=8).
// Inputs change 1 ns after each rising edge; outputs are checked at that same point.
// Expected values are hand-derived from the request/blink/lockout behaviour.
module tb_ped_request;

  logic       clk_50_mhz;
  logic       rst;
  logic       btn_n;
  logic       ack;
  logic       req;
  logic       wait_lamp;
  logic       press_pulse;
  logic [7:0] press_count;

  int total_checks;
  int passed_checks;
  int failed_checks;

  ped_request #(
    .BLINK_HALF     (4),
    .LOCKOUT_CYCLES (8),
    .CNT_W          (8)
  ) dut (
    .clk_50_mhz  (clk_50_mhz),
    .rst         (rst),
    .btn_n       (btn_n),
    .ack         (ack),
    .req         (req),
    .wait_lamp   (wait_lamp),
    .press_pulse (press_pulse),
    .press_count (press_count)
  );

  initial clk_50_mhz = 1'b0;
  always #5 clk_50_mhz = ~clk_50_mhz;

  task automatic step();
    @(posedge clk_50_mhz);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    assert (obs === exp) passed_checks++;
    else begin
      failed_checks++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic [11:0] exp_lamp;
    total_checks  = 0;
    passed_checks = 0;
    failed_checks = 0;
    exp_lamp      = 12'b1111_0000_1111;

    // Reset with the button already held down
    rst   = 1'b1;
    btn_n = 1'b0;
    ack   = 1'b0;
    step();
    step();
    check("rst_req",   req,         0);
    check("rst_lamp",  wait_lamp,   0);
    check("rst_pulse", press_pulse, 0);
    check("rst_count", press_count, 0);

    // Held through reset release: no request
    rst = 1'b0;
    step(); step(); step();
    check("held_rst_req",   req,         0);
    check("held_rst_count", press_count, 0);
    btn_n = 1'b1;
    step(); step();
    check("held_rst_release_req", req, 0);

    // First press, then blink pattern 1111 0000 1111
    btn_n = 1'b0;
    step();
    check("p1_req",   req,         1);
    check("p1_pulse", press_pulse, 1);
    check("p1_count", press_count, 1);
    check("lamp_0",   wait_lamp,   exp_lamp[0]);
    btn_n = 1'b1;
    for (int k = 1; k < 12; k++) begin
      step();
      check($sformatf("lamp_%0d", k), wait_lamp, exp_lamp[k]);
      check($sformatf("pend_pulse_%0d", k), press_pulse, 0);
    end

    // Three more presses while pending
    for (int i = 0; i < 3; i++) begin
      btn_n = 1'b0;
      step();
      check($sformatf("pend_press_pulse_%0d", i), press_pulse, 1);
      check($sformatf("pend_press_req_%0d", i),   req,         1);
      btn_n = 1'b1;
      step();
      check($sformatf("pend_release_pulse_%0d", i), press_pulse, 0);
    end
    check("pend_count", press_count, 4);
    check("pend_req",   req,         1);

    // ack with a coincident press: ack wins
    ack   = 1'b1;
    btn_n = 1'b0;
    step();
    ack = 1'b0;
    check("ack_req",   req,         0);
    check("ack_lamp",  wait_lamp,   0);
    check("ack_pulse", press_pulse, 0);
    check("ack_count", press_count, 4);

    // Press inside lockout, held past its end: ignored
    btn_n = 1'b1;
    step(); step();
    btn_n = 1'b0;
    step();
    check("lock_press_req",   req,         0);
    check("lock_press_pulse", press_pulse, 0);
    repeat (8) step();
    check("lock_held_req",   req,         0);
    check("lock_held_count", press_count, 4);
    check("lock_held_lamp",  wait_lamp,   0);
    btn_n = 1'b1;
    step();
    btn_n = 1'b0;
    step();
    check("idle_repress_req",   req,         1);
    check("idle_repress_pulse", press_pulse, 1);
    check("idle_repress_count", press_count, 5);
    btn_n = 1'b1;
    step();

    // Lockout edge: a press sampled on the 9th lockout edge is still discarded
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("x_ack_req", req, 0);
    repeat (8) step();
    btn_n = 1'b0;
    step();
    check("lock_last_req",   req,         0);
    check("lock_last_count", press_count, 5);
    btn_n = 1'b1;
    step();
    btn_n = 1'b0;
    step();
    check("after_lock_req",   req,         1);
    check("after_lock_count", press_count, 6);
    btn_n = 1'b1;
    step();

    // Lockout edge: a press sampled on the 10th edge after ack is accepted
    ack = 1'b1;
    step();
    ack = 1'b0;
    repeat (9) step();
    btn_n = 1'b0;
    step();
    check("first_idle_req",   req,         1);
    check("first_idle_pulse", press_pulse, 1);
    check("first_idle_count", press_count, 7);
    btn_n = 1'b1;
    step(); step(); step();
    check("mid_pend_lamp", wait_lamp, 1);

    // Asynchronous reset mid-pending clears everything before any edge
    rst = 1'b1;
    #1;
    check("async_rst_req",   req,         0);
    check("async_rst_lamp",  wait_lamp,   0);
    check("async_rst_pulse", press_pulse, 0);
    check("async_rst_count", press_count, 0);
    step();
    rst = 1'b0;
    step();

    // 260 full press/ack/lockout rounds: counter saturates at 255
    for (int i = 0; i < 260; i++) begin
      btn_n = 1'b0;
      step();
      if (i == 253) check("sat_254", press_count, 254);
      if (i == 254) check("sat_255", press_count, 255);
      if (i == 259) check("sat_pulse", press_pulse, 1);
      btn_n = 1'b1;
      ack   = 1'b1;
      step();
      ack = 1'b0;
      repeat (10) step();
    end
    check("sat_final_count", press_count, 255);
    check("sat_final_req",   req,         0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
